// File: rtl/imem_loader_pkg.sv
// Shared state encoding and default constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int          INSTR_W           = 16;
    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0000;
    localparam int          DEFAULT_DEPTH     = 256;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic logic accepts_byte(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and CPU status of the loader.
interface imem_loader_if #(
    parameter int LEN_W = 16
);
    logic                                 start;
    logic [7:0]                           byte_in;
    logic                                 byte_valid;
    logic                                 byte_ready;
    logic                                 im_write;
    logic [15:0]                          im_addr;
    logic [imem_loader_pkg::INSTR_W-1:0]  im_data;
    logic                                 cpu_hold;
    logic                                 done;
    logic                                 error;
    logic [LEN_W-1:0]                     word_count;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, im_write, im_addr, im_data, cpu_hold, done, error, word_count
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, im_write, im_addr, im_data, cpu_hold, done, error, word_count
    );
endinterface

// File: rtl/loader_byte_packer.sv
// Pairs stream bytes into big-endian words and keeps the running XOR of every byte taken.
module loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               take,
    input  logic               take_hi,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic [7:0]         csum
);
    logic [7:0] hi_q, hi_d;
    logic [7:0] csum_q, csum_d;

    always_comb begin
        hi_d   = hi_q;
        csum_d = csum_q;
        if (clear) begin
            csum_d = 8'h00;
        end else if (take) begin
            csum_d = csum_q ^ byte_in;
            if (take_hi) begin
                hi_d = byte_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= 8'h00;
            csum_q <= 8'h00;
        end else begin
            hi_q   <= hi_d;
            csum_q <= csum_d;
        end
    end

    // The low byte is the one being taken this cycle, so the word is ready on that edge.
    assign word = {hi_q, byte_in};
    assign csum = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a length-prefixed byte stream while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter int          LEN_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_DATA = ST_CHK;
`else
    localparam state_e AFTER_DATA = ST_DONE;
`endif

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [LEN_W-1:0]   word_count_q, word_count_d;
    logic [LEN_W-1:0]   wc_next;
    logic [15:0]        im_addr_q, im_addr_d;
    logic [INSTR_W-1:0] im_data_q, im_data_d;
    logic               byte_ready_q, byte_ready_d;
    logic               im_write_q, im_write_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               take;
    logic               take_hi;
    logic               clear;
    logic [INSTR_W-1:0] pk_word;
    logic [7:0]         pk_csum;

    assign take    = bus.byte_valid && byte_ready_q;
    assign take_hi = (state_q == ST_LEN_HI) || (state_q == ST_DATA_HI);
    assign clear   = (state_q == ST_IDLE) && bus.start;
    assign wc_next = word_count_q + LEN_W'(1);

    loader_byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .take    (take),
        .take_hi (take_hi),
        .byte_in (bus.byte_in),
        .word    (pk_word),
        .csum    (pk_csum)
    );

`ifndef IMEM_LOADER_CHECKSUM_EN
    logic unused_csum;
    assign unused_csum = ^pk_csum;
`endif

    always_comb begin
        state_d      = state_q;
        length_d     = length_q;
        word_count_d = word_count_q;
        im_addr_d    = im_addr_q;
        im_data_d    = im_data_q;
        error_d      = error_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_LEN_HI;
                    error_d      = 1'b0;
                    word_count_d = '0;
                end
            end
            ST_LEN_HI: begin
                if (take) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (take) begin
                    length_d = LEN_W'(pk_word);
                    if (pk_word == '0) begin
                        state_d = AFTER_DATA;
                    end else if (32'(pk_word) > DEPTH) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (take) state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (take) begin
                    state_d   = ST_WRITE;
                    im_addr_d = BASE_ADDR + 16'(word_count_q);
                    im_data_d = pk_word;
                end
            end
            ST_WRITE: begin
                word_count_d = wc_next;
                state_d      = (wc_next == length_q) ? AFTER_DATA : ST_DATA_HI;
            end
            ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (take) state_d = (bus.byte_in == pk_csum) ? ST_DONE : ST_ERR;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        if (state_d == ST_ERR) error_d = 1'b1;
        byte_ready_d = accepts_byte(state_d);
        im_write_d   = (state_d == ST_WRITE);
        cpu_hold_d   = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            length_q     <= '0;
            word_count_q <= '0;
            im_addr_q    <= 16'h0000;
            im_data_q    <= '0;
            byte_ready_q <= 1'b0;
            im_write_q   <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            length_q     <= length_d;
            word_count_q <= word_count_d;
            im_addr_q    <= im_addr_d;
            im_data_q    <= im_data_d;
            byte_ready_q <= byte_ready_d;
            im_write_q   <= im_write_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.im_write   = im_write_q;
    assign bus.im_addr    = im_addr_q;
    assign bus.im_data    = im_data_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream-level model queues expected writes and load outcomes.
module tb_imem_loader;

    localparam logic [15:0] BASE  = 16'h0000;
    localparam int          DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.LEN_W(16)) bus ();

    imem_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
    typedef struct { bit is_err; logic [15:0] wc; } end_t;

    wr_t        write_q[$];
    end_t       end_q[$];
    logic [7:0] stream[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes or finishes a load.
    initial begin
        bit   done_prev;
        bit   error_prev;
        bit   done_seen;
        wr_t  w;
        end_t e;
        done_prev  = 1'b0;
        error_prev = 1'b0;
        done_seen  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev  = 1'b0;
                error_prev = 1'b0;
                done_seen  = 1'b0;
            end else begin
                if (done_seen) begin
                    check("hold_after_done", bus.cpu_hold, 0);
                    done_seen = 1'b0;
                end
                if (bus.im_write) begin
                    check("ready_during_write", bus.byte_ready, 0);
                    check("hold_during_write", bus.cpu_hold, 1);
                    check("write_expected", write_q.size() != 0, 1);
                    if (write_q.size() != 0) begin
                        w = write_q.pop_front();
                        check("write_addr", bus.im_addr, w.addr);
                        check("write_data", bus.im_data, w.data);
                    end
                end
                if (bus.done) begin
                    check("done_single_cycle", done_prev, 0);
                    check("done_expected", end_q.size() != 0, 1);
                    if (end_q.size() != 0) begin
                        e = end_q.pop_front();
                        check("done_not_error", e.is_err, 0);
                        check("done_word_count", bus.word_count, e.wc);
                        check("done_writes_drained", write_q.size(), 0);
                    end
                    done_seen = 1'b1;
                end
                if (bus.error && !error_prev) begin
                    check("error_expected", end_q.size() != 0, 1);
                    if (end_q.size() != 0) begin
                        e = end_q.pop_front();
                        check("error_kind", e.is_err, 1);
                        check("error_word_count", bus.word_count, e.wc);
                        check("error_hold", bus.cpu_hold, 1);
                    end
                end
                done_prev  = bus.done;
                error_prev = bus.error;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.cpu_hold && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", bus.cpu_hold, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.byte_ready) begin
            check("byte_ready_wait", bus.byte_ready, 1);
        end else begin
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic start_load();
        wait_idle();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("start_clears_error", bus.error, 0);
        check("start_clears_count", bus.word_count, 0);
        check("start_sets_hold", bus.cpu_hold, 1);
    endtask

    task automatic append_chk(input bit corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stream[k]) x ^= stream[k];
        stream.push_back(corrupt ? (x ^ 8'h5A) : x);
`else
        if (corrupt) stream.push_back(8'h00);
        if (corrupt) void'(stream.pop_back());
`endif
    endtask

    task automatic build_stream(input int len, input bit corrupt);
        stream.delete();
        stream.push_back(8'(len >> 8));
        stream.push_back(8'(len));
        if (len <= DEPTH) begin
            for (int i = 0; i < 2 * len; i++) stream.push_back(8'($urandom_range(0, 255)));
            append_chk(corrupt);
        end
    endtask

    // Reference model: derives the writes and the outcome from the byte stream alone.
    task automatic push_model();
        int len;
        len = {stream[0], stream[1]};
        if (len > DEPTH) begin
            end_q.push_back('{1'b1, 16'h0000});
        end else begin
            for (int i = 0; i < len; i++)
                write_q.push_back('{BASE + 16'(i), {stream[2 + 2 * i], stream[3 + 2 * i]}});
`ifdef IMEM_LOADER_CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                for (int j = 0; j < 2 + 2 * len; j++) x ^= stream[j];
                end_q.push_back('{stream[2 + 2 * len] != x, 16'(len)});
            end
`else
            end_q.push_back('{1'b0, 16'(len)});
`endif
        end
    endtask

    task automatic applyStimulus(input int gap_mode);
        push_model();
        start_load();
        foreach (stream[k]) begin
            send_byte(stream[k]);
            if (gap_mode == 1) begin
                @(posedge clk); #1;
            end else if (gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        wait_idle();
    endtask

    initial begin
        int len;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_byte_ready", bus.byte_ready, 0);
        check("reset_im_write", bus.im_write, 0);
        check("reset_im_addr", bus.im_addr, 0);
        check("reset_im_data", bus.im_data, 0);
        check("reset_cpu_hold", bus.cpu_hold, 0);
        check("reset_done", bus.done, 0);
        check("reset_error", bus.error, 0);
        check("reset_word_count", bus.word_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        stream = '{8'h00, 8'h03, 8'h06, 8'hA0, 8'h20, 8'h04, 8'h06, 8'h0A};
        append_chk(1'b0);
        applyStimulus(0);
        check("basic_final_count", bus.word_count, 3);

        stream = '{8'h00, 8'h03, 8'h06, 8'hA0, 8'h20, 8'h04, 8'h06, 8'h0A};
        append_chk(1'b0);
        applyStimulus(1);

        stream = '{8'h00, 8'h00};
        append_chk(1'b0);
        applyStimulus(0);
        check("zero_len_count", bus.word_count, 0);

        stream = '{8'h01, 8'h01};
        applyStimulus(0);
        check("error_sticky", bus.error, 1);
        repeat (3) @(posedge clk);
        #1;
        check("error_still_sticky", bus.error, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        stream = '{8'h00, 8'h01, 8'hA0, 8'h00, 8'hA1};
        applyStimulus(0);
        check("chk_good_no_error", bus.error, 0);
        stream = '{8'h00, 8'h01, 8'hA0, 8'h00, 8'hA2};
        applyStimulus(0);
        check("chk_bad_error", bus.error, 1);
        check("chk_bad_addr", bus.im_addr, BASE);
        check("chk_bad_data", bus.im_data, 16'hA000);
`endif

        build_stream(DEPTH, 1'b0);
        applyStimulus(0);
        check("full_depth_count", bus.word_count, DEPTH);

        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = DEPTH + 1 + int'($urandom_range(0, 300));
                default: len = int'($urandom_range(1, 6));
            endcase
            build_stream(len, $urandom_range(0, 3) == 0);
            applyStimulus(int'($urandom_range(0, 2)));
        end

        build_stream(5, 1'b0);
        for (int i = 0; i < 3; i++)
            write_q.push_back('{BASE + 16'(i), {stream[2 + 2 * i], stream[3 + 2 * i]}});
        start_load();
        for (int k = 0; k < 8; k++) send_byte(stream[k]);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_byte_ready", bus.byte_ready, 0);
        check("abort_im_write", bus.im_write, 0);
        check("abort_im_addr", bus.im_addr, 0);
        check("abort_im_data", bus.im_data, 0);
        check("abort_cpu_hold", bus.cpu_hold, 0);
        check("abort_done", bus.done, 0);
        check("abort_word_count", bus.word_count, 0);
        check("abort_writes_seen", write_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        build_stream(1, 1'b0);
        applyStimulus(0);
        check("after_abort_addr", bus.im_addr, BASE);
        check("after_abort_count", bus.word_count, 1);

        repeat (4) @(posedge clk);
        #1;
        check("writes_outstanding", write_q.size(), 0);
        check("ends_outstanding", end_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
